vga_line_sched: RTL and testbench

- Scheduler between the NES PPU pixel stream and the VGA scan-doubling driver.
- Owns a 2-line ping-pong line buffer (external dual-port RAM, 512 x 6-bit): steers PPU writes into the back bank and VGA reads from the front bank.
- Generates the driver's one-cycle frame sync pulse so VGA line 0 starts one NES line behind the PPU.
- Monitors phase lock every frame and re-syncs after repeated slips.

---
 rtl/vga_pkg.sv | 22 ++
 rtl/vga_line_sched_if.sv | 36 +++
 rtl/vga_lock_mon.sv | 57 +++++
 rtl/vga_line_sched.sv | 109 ++++++++++
 tb/tb_vga_line_sched.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared constants, state encoding and address helpers for the PPU-to-VGA line scheduler.
package vga_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SEARCH = 2'd1;
    localparam logic [1:0] SYNC   = 2'd2;
    localparam logic [1:0] LOCKED = 2'd3;

    localparam int unsigned PIC_LINES = 480;
    localparam int unsigned NES_LINES = 240;
    localparam int unsigned LINE_W    = 256;

    function automatic logic is_vis_line(input logic [8:0] y);
        return y < 9'(NES_LINES);
    endfunction

    // Line RAM address: bank bit above the pixel column.
    function automatic logic [8:0] line_addr(input logic bank, input logic [7:0] x);
        return {bank, x};
    endfunction

endpackage

// File: rtl/vga_line_sched_if.sv
// Signal bundle between the scheduler, the PPU stream, the VGA driver and the line RAM.
interface vga_line_sched_if;

    logic       enable;
    logic       ppu_we;
    logic [7:0] ppu_x;
    logic [8:0] ppu_y;
    logic [5:0] ppu_color;
    logic [9:0] vga_hcounter;
    logic [9:0] vga_vcounter;
    logic [9:0] next_pixel_x;

    logic       vga_sync;
    logic       buf_we;
    logic [8:0] buf_waddr;
    logic [5:0] buf_wdata;
    logic [8:0] buf_raddr;
    logic       locked;
    logic       collision;
    logic [7:0] resync_cnt;

    modport master (
        input  enable, ppu_we, ppu_x, ppu_y, ppu_color,
        input  vga_hcounter, vga_vcounter, next_pixel_x,
        output vga_sync, buf_we, buf_waddr, buf_wdata, buf_raddr,
        output locked, collision, resync_cnt
    );

    modport slave (
        output enable, ppu_we, ppu_x, ppu_y, ppu_color,
        output vga_hcounter, vga_vcounter, next_pixel_x,
        input  vga_sync, buf_we, buf_waddr, buf_wdata, buf_raddr,
        input  locked, collision, resync_cnt
    );

endinterface

// File: rtl/vga_lock_mon.sv
// Frame-start phase check: counts consecutive slips and requests a relock after MAX_MISS of them.
module vga_lock_mon #(
    parameter int unsigned SLIP_WIN = 4,
    parameter int unsigned MAX_MISS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       check_en_i,
    input  logic       clear_i,
    input  logic [9:0] vga_hcounter_i,
    input  logic [9:0] vga_vcounter_i,
    output logic       relock_req_o,
    output logic [7:0] resync_cnt_o
);

    localparam int unsigned MissW = (MAX_MISS > 1) ? $clog2(MAX_MISS + 1) : 1;

    logic [MissW-1:0] miss_q, miss_d;
    logic [7:0]       resync_q, resync_d;
    logic             check_pass;
    logic             relock;

    assign check_pass = (vga_vcounter_i == 10'd0) && (vga_hcounter_i <= 10'(SLIP_WIN));
    // The slip that would bring the count to MAX_MISS triggers the relock directly.
    assign relock = check_en_i && !check_pass && (miss_q == MissW'(MAX_MISS - 1));

    always_comb begin
        miss_d   = miss_q;
        resync_d = resync_q;
        if (clear_i) begin
            miss_d = '0;
        end else if (check_en_i) begin
            if (check_pass || relock) begin
                miss_d = '0;
            end else begin
                miss_d = miss_q + 1'b1;
            end
        end
        if (relock && (resync_q != 8'hFF)) begin
            resync_d = resync_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            miss_q   <= '0;
            resync_q <= 8'd0;
        end else begin
            miss_q   <= miss_d;
            resync_q <= resync_d;
        end
    end

    assign relock_req_o = relock;
    assign resync_cnt_o = resync_q;

endmodule

// File: rtl/vga_line_sched.sv
// Ping-pong line buffer steering and frame-sync generation between the NES PPU and VGA driver.
module vga_line_sched
    import vga_pkg::*;
#(
    parameter int unsigned SLIP_WIN = 4,
    parameter int unsigned MAX_MISS = 3,
    parameter logic [7:0]  LAST_X   = 8'd255
) (
    input logic               clk,
    input logic               reset,
    vga_line_sched_if.master  bus
);

    logic [1:0] state_q, state_d;
    logic       buf_we_q, buf_we_d;
    logic [8:0] buf_waddr_q, buf_waddr_d;
    logic [5:0] buf_wdata_q, buf_wdata_d;
    logic       collision_q, collision_d;

    logic       frame_end;
    logic       running;
    logic       wr_ok;
    logic       bank_clash;
    logic       check_en;
    logic       relock_req;
    logic [7:0] resync_cnt;
    logic       unused_npx;

    assign frame_end = bus.ppu_we && (bus.ppu_y == 9'd0) && (bus.ppu_x == LAST_X);

    // enable low counts as IDLE this cycle, not only from the next one.
    assign running = bus.enable && (state_q != IDLE);
    assign wr_ok   = bus.ppu_we && is_vis_line(bus.ppu_y) && running;

    assign bank_clash = (bus.vga_vcounter < 10'(PIC_LINES))
                     && (bus.ppu_y[0] == bus.vga_vcounter[1]);

    assign check_en = (state_q == LOCKED) && bus.enable && frame_end;

    vga_lock_mon #(
        .SLIP_WIN (SLIP_WIN),
        .MAX_MISS (MAX_MISS)
    ) u_lock_mon (
        .clk            (clk),
        .reset          (reset),
        .check_en_i     (check_en),
        .clear_i        (state_q == SYNC),
        .vga_hcounter_i (bus.vga_hcounter),
        .vga_vcounter_i (bus.vga_vcounter),
        .relock_req_o   (relock_req),
        .resync_cnt_o   (resync_cnt)
    );

    always_comb begin
        state_d = state_q;
        if (!bus.enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = SEARCH;
                SEARCH:  if (frame_end) state_d = SYNC;
                SYNC:    state_d = LOCKED;
                LOCKED:  if (relock_req) state_d = SEARCH;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        buf_we_d    = wr_ok;
        buf_waddr_d = buf_waddr_q;
        buf_wdata_d = buf_wdata_q;
        if (wr_ok) begin
            buf_waddr_d = line_addr(bus.ppu_y[0], bus.ppu_x);
            buf_wdata_d = bus.ppu_color;
        end
        // Sticky; the write itself is never suppressed.
        collision_d = collision_q || ((state_q == LOCKED) && wr_ok && bank_clash);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            buf_we_q    <= 1'b0;
            buf_waddr_q <= 9'd0;
            buf_wdata_q <= 6'd0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_we_q    <= buf_we_d;
            buf_waddr_q <= buf_waddr_d;
            buf_wdata_q <= buf_wdata_d;
            collision_q <= collision_d;
        end
    end

    // Each NES pixel covers two VGA pixels and each NES line two VGA lines.
    assign bus.buf_raddr = line_addr(bus.vga_vcounter[1], bus.next_pixel_x[8:1]);
    assign unused_npx    = bus.next_pixel_x[9] ^ bus.next_pixel_x[0];

    assign bus.vga_sync   = (state_q == SYNC);
    assign bus.locked     = (state_q == LOCKED);
    assign bus.buf_we     = buf_we_q;
    assign bus.buf_waddr  = buf_waddr_q;
    assign bus.buf_wdata  = buf_wdata_q;
    assign bus.collision  = collision_q;
    assign bus.resync_cnt = resync_cnt;

endmodule

// File: tb/tb_vga_line_sched.sv
// Directed and randomized checks of vga_line_sched against a cycle-level behavioural model.
module tb_vga_line_sched;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    vga_line_sched_if bus();

    vga_line_sched #(
        .SLIP_WIN (4),
        .MAX_MISS (3),
        .LAST_X   (8'd255)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Model: mode 0 off, 1 hunting, 2 pulse, 3 tracking.
    int mode, miss, resync;
    bit coll, m_we, was_reset;
    int m_waddr, m_wdata;
    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit we, input int y, input int x, input int c);
        bus.ppu_we    = we;
        bus.ppu_y     = 9'(y);
        bus.ppu_x     = 8'(x);
        bus.ppu_color = 6'(c);
    endtask

    task automatic tick();
        int  y, x, v, h;
        bit  fe, wr;
        y  = int'(bus.ppu_y);
        x  = int'(bus.ppu_x);
        v  = int'(bus.vga_vcounter);
        h  = int'(bus.vga_hcounter);
        fe = bus.ppu_we && y == 0 && x == 255;
        was_reset = reset;
        if (reset) begin
            mode = 0; miss = 0; resync = 0; coll = 0;
            m_we = 0; m_waddr = 0; m_wdata = 0;
        end else begin
            wr = bus.ppu_we && y < 240 && bus.enable && mode != 0;
            if (wr && mode == 3 && v < 480 && (y % 2) == ((v / 2) % 2)) coll = 1;
            m_we = wr;
            if (wr) begin
                m_waddr = (y % 2) * 256 + x;
                m_wdata = int'(bus.ppu_color);
            end
            if (mode == 2) miss = 0;
            if (!bus.enable) begin
                mode = 0;
            end else if (mode == 0) begin
                mode = 1;
            end else if (mode == 1) begin
                if (fe) mode = 2;
            end else if (mode == 2) begin
                mode = 3;
            end else if (fe) begin
                if (v == 0 && h <= 4) miss = 0;
                else miss++;
                if (miss == 3) begin
                    miss = 0;
                    mode = 1;
                    if (resync < 255) resync++;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("vga_sync", bus.vga_sync, mode == 2);
        chk("locked", bus.locked, mode == 3);
        chk("buf_we", bus.buf_we, m_we);
        if (m_we || was_reset) begin
            chk("buf_waddr", bus.buf_waddr, m_waddr);
            chk("buf_wdata", bus.buf_wdata, m_wdata);
        end
        chk("collision", bus.collision, coll);
        chk("resync_cnt", bus.resync_cnt, resync);
        chk("buf_raddr", bus.buf_raddr,
            ((int'(bus.vga_vcounter) / 2) % 2) * 256 + (int'(bus.next_pixel_x) / 2) % 256);
    endtask

    task automatic frame_end_at(input int v, input int h);
        bus.vga_vcounter = 10'(v);
        bus.vga_hcounter = 10'(h);
        drive(1, 0, 255, 5);
        tick();
        drive(0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1;
        bus.enable = 1'b0;
        drive(0, 0, 0, 0);
        bus.vga_hcounter = '0;
        bus.vga_vcounter = '0;
        bus.next_pixel_x = '0;
        tick();
        tick();
        chk("reset_raddr", bus.buf_raddr, 0);

        // First lock: SEARCH, frame_end, one-cycle sync pulse, then LOCKED.
        reset = 1'b0;
        bus.enable = 1'b1;
        tick();
        drive(1, 0, 255, 1);
        tick();
        chk("sync_pulse", bus.vga_sync, 1);
        drive(0, 0, 0, 0);
        tick();
        chk("first_lock", bus.locked, 1);
        chk("sync_single", bus.vga_sync, 0);

        // Write path and dropped non-visible line.
        drive(1, 5, 17, 'h2A);
        tick();
        chk("wr_addr_vec", bus.buf_waddr, 'h111);
        chk("wr_data_vec", bus.buf_wdata, 'h2A);
        drive(1, 245, 3, 7);
        tick();
        chk("wr_drop_245", bus.buf_we, 0);
        drive(0, 0, 0, 0);

        // Read path.
        bus.vga_vcounter = 10'd6;
        bus.next_pixel_x = 10'h0C9;
        tick();
        chk("raddr_vec", bus.buf_raddr, 'h164);

        // Three slips force a relock, then the next frame_end re-syncs.
        frame_end_at(12, 0);
        frame_end_at(12, 0);
        frame_end_at(12, 0);
        chk("slip_unlock", bus.locked, 0);
        chk("slip_resync", bus.resync_cnt, 1);
        frame_end_at(12, 0);
        chk("resync_pulse", bus.vga_sync, 1);
        tick();
        chk("relocked", bus.locked, 1);

        // A passing check clears the miss count.
        frame_end_at(12, 0);
        frame_end_at(12, 0);
        frame_end_at(0, 2);
        frame_end_at(12, 0);
        frame_end_at(12, 0);
        chk("pass_keeps_lock", bus.locked, 1);
        chk("pass_no_resync", bus.resync_cnt, 1);

        // Disable while locked, then reset in the SYNC cycle.
        bus.enable = 1'b0;
        tick();
        chk("disable_unlock", bus.locked, 0);
        drive(1, 7, 3, 9);
        tick();
        chk("disable_no_we", bus.buf_we, 0);
        drive(0, 0, 0, 0);
        bus.enable = 1'b1;
        tick();
        frame_end_at(0, 0);
        chk("pre_reset_sync", bus.vga_sync, 1);
        reset = 1'b1;
        tick();
        chk("reset_sync", bus.vga_sync, 0);
        chk("reset_resync", bus.resync_cnt, 0);
        chk("reset_coll", bus.collision, 0);
        reset = 1'b0;

        // Collision: write into the bank being displayed.
        tick();
        frame_end_at(0, 0);
        tick();
        bus.vga_vcounter = 10'd2;
        drive(1, 3, 9, 4);
        tick();
        chk("collision_set", bus.collision, 1);
        drive(0, 0, 0, 0);
        repeat (3) tick();
        chk("collision_sticky", bus.collision, 1);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            reset      = ($urandom_range(0, 299) == 0);
            bus.enable = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 9) < 2) begin
                drive(1, 0, 255, int'($urandom_range(0, 63)));
            end else begin
                drive($urandom_range(0, 1) == 1, int'($urandom_range(0, 261)),
                      int'($urandom_range(0, 255)), int'($urandom_range(0, 63)));
            end
            bus.vga_vcounter = ($urandom_range(0, 2) == 0) ? 10'd0
                                                           : 10'($urandom_range(0, 524));
            bus.vga_hcounter = ($urandom_range(0, 3) != 0) ? 10'($urandom_range(0, 8))
                                                           : 10'($urandom_range(0, 799));
            bus.next_pixel_x = 10'($urandom_range(0, 799));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
